// File: rtl/dcm_reset_sequencer_if.sv
// Control/status bundle between the DCM reset sequencer and the DCM/system.
// master = sequencer side, slave = DCM and system side.
interface dcm_reset_sequencer_if;
   logic       dcm_locked;
   logic [7:0] dcm_status;
   logic       dcm_rst;
   logic       sys_rst;
   logic       ready;
   logic       lock_lost;
   logic [7:0] retry_count;

   modport master (
      input  dcm_locked,
      input  dcm_status,
      output dcm_rst,
      output sys_rst,
      output ready,
      output lock_lost,
      output retry_count
   );

   modport slave (
      output dcm_locked,
      output dcm_status,
      input  dcm_rst,
      input  sys_rst,
      input  ready,
      input  lock_lost,
      input  retry_count
   );
endinterface

// File: rtl/dcm_reset_sequencer.sv
// Holds the system in reset until the DCM is locked and stable; re-resets
// the DCM on lock timeout, lock loss or input-clock-stopped status.
module dcm_reset_sequencer #(
   parameter int RST_PULSE_CYCLES = 4,
   parameter int LOCK_TIMEOUT     = 65535,
   parameter int SETTLE_CYCLES    = 16
) (
   input logic                   clk,
   input logic                   rst,
   dcm_reset_sequencer_if.master dcm
);

   localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ?
                           RST_PULSE_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > SETTLE_CYCLES) ?
                           MAX_AB : SETTLE_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      RESET_DCM,
      WAIT_LOCK,
      SETTLE,
      RUN
   } state_t;

   state_t        state, nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    lk_sync, stp_sync;
   logic          lk_s, stp_s, ok;
   logic          bump, lost;
   logic          unused_status;

   assign unused_status = ^{dcm.dcm_status[7:2], dcm.dcm_status[0]};
   assign lk_s  = lk_sync[1];
   assign stp_s = stp_sync[1];
   assign ok    = lk_s & ~stp_s;

   // Both inputs are asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_sync  <= '0;
         stp_sync <= '0;
      end else begin
         lk_sync  <= {lk_sync[0], dcm.dcm_locked};
         stp_sync <= {stp_sync[0], dcm.dcm_status[1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_DCM;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt + 1'b1;
      bump    = 1'b0;
      lost    = 1'b0;
      unique case (state)
         RESET_DCM: begin
            if (cnt == RST_LAST) begin
               nxt     = WAIT_LOCK;
               cnt_nxt = '0;
            end
         end
         WAIT_LOCK: begin
            if (ok) begin
               nxt     = SETTLE;
               cnt_nxt = '0;
            end else if (cnt == TMO_LAST) begin
               nxt     = RESET_DCM;
               cnt_nxt = '0;
               bump    = 1'b1;
            end
         end
         SETTLE: begin
            if (!ok) begin
               nxt     = RESET_DCM;
               cnt_nxt = '0;
               bump    = 1'b1;
            end else if (cnt == SET_LAST) begin
               nxt     = RUN;
               cnt_nxt = '0;
            end
         end
         RUN: begin
            cnt_nxt = '0;
            if (!ok) begin
               nxt  = RESET_DCM;
               bump = 1'b1;
               lost = 1'b1;
            end
         end
         default: begin
            nxt     = RESET_DCM;
            cnt_nxt = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcm.dcm_rst     <= 1'b1;
         dcm.sys_rst     <= 1'b1;
         dcm.ready       <= 1'b0;
         dcm.lock_lost   <= 1'b0;
         dcm.retry_count <= '0;
      end else begin
         dcm.dcm_rst   <= (nxt == RESET_DCM);
         dcm.sys_rst   <= (nxt != RUN);
         dcm.ready     <= (nxt == RUN);
         dcm.lock_lost <= lost;
         if (bump && (dcm.retry_count != 8'hFF))
            dcm.retry_count <= dcm.retry_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Randomized and directed bench for dcm_reset_sequencer against a
// phase/elapsed-time reference model.
module tb_dcm_reset_sequencer;

   localparam int RP = 4;
   localparam int LT = 20;
   localparam int SC = 8;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_SET  = 2;
   localparam int P_RUN  = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dcm_reset_sequencer_if bus ();

   dcm_reset_sequencer #(
      .RST_PULSE_CYCLES (RP),
      .LOCK_TIMEOUT     (LT),
      .SETTLE_CYCLES    (SC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .dcm (bus)
   );

   int total = 0;
   int bad   = 0;

   int ph, el, retries;
   bit mlost;
   bit ms1, ms2, mt1, mt2;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph      = P_RST;
      el      = 0;
      retries = 0;
      mlost   = 0;
      ms1 = 0; ms2 = 0; mt1 = 0; mt2 = 0;
   endtask

   task automatic go(int p);
      ph = p;
      el = 0;
   endtask

   // el = number of full cycles completed in the current phase.
   task automatic model_step(bit lk, bit stp);
      bit good;
      good  = ms2 && !mt2;
      mlost = 0;
      el++;
      case (ph)
         P_RST:  if (el == RP) go(P_WAIT);
         P_WAIT: begin
            if (good) go(P_SET);
            else if (el == LT) begin go(P_RST); retries++; end
         end
         P_SET: begin
            if (!good) begin go(P_RST); retries++; end
            else if (el == SC) go(P_RUN);
         end
         default: begin
            if (!good) begin
               go(P_RST);
               retries++;
               mlost = 1;
            end
         end
      endcase
      ms2 = ms1; ms1 = lk;
      mt2 = mt1; mt1 = stp;
   endtask

   task automatic compare_all();
      chk("dcm_rst",   32'(bus.dcm_rst),     32'(ph == P_RST));
      chk("sys_rst",   32'(bus.sys_rst),     32'(ph != P_RUN));
      chk("ready",     32'(bus.ready),       32'(ph == P_RUN));
      chk("lock_lost", 32'(bus.lock_lost),   32'(mlost));
      chk("retry",     32'(bus.retry_count), (retries > 255) ? 255 : retries);
   endtask

   task automatic tick(bit lk, bit stp, logic [7:0] other);
      logic [7:0] s;
      s = other;
      s[1] = stp;
      bus.dcm_locked = lk;
      bus.dcm_status = s;
      @(posedge clk);
      model_step(lk, stp);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_dcm_rst"}, 32'(bus.dcm_rst),     1);
      chk({tag, "_sys_rst"}, 32'(bus.sys_rst),     1);
      chk({tag, "_ready"},   32'(bus.ready),       0);
      chk({tag, "_lost"},    32'(bus.lock_lost),   0);
      chk({tag, "_retry"},   32'(bus.retry_count), 0);
   endtask

   task automatic do_reset(bit lk);
      bus.dcm_locked = lk;
      bus.dcm_status = 8'h00;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_vals("rst");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit lk, stp, reached;
      rst = 1'b1;
      bus.dcm_locked = 1'b0;
      bus.dcm_status = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("init");
      rst = 1'b0;

      // Normal bring-up
      repeat (10) tick(0, 0, 8'h00);
      repeat (20) tick(1, 0, 8'h00);
      chk("bringup_ready", 32'(bus.ready), 1);
      chk("bringup_retry", 32'(bus.retry_count), 0);

      // Loss of lock in RUN, then relock
      repeat (10) tick(0, 0, 8'h00);
      repeat (30) tick(1, 0, 8'h00);
      chk("relock_ready", 32'(bus.ready), 1);

      // CLKIN stopped with lock still high, then relock
      repeat (3) tick(1, 1, 8'h00);
      repeat (30) tick(1, 0, 8'h00);
      chk("stp_retry", 32'(bus.retry_count), 2);

      // Ignored status bits toggling in RUN
      for (int i = 0; i < 20; i++)
         tick(1, 0, 8'($urandom));
      chk("ign_ready", 32'(bus.ready), 1);

      // Settle dropout at elapsed 5
      do_reset(1);
      reached = 0;
      for (int i = 0; i < 100 && !reached; i++) begin
         tick(1, 0, 8'h00);
         reached = (ph == P_SET) && (el == 5);
      end
      chk("settle_reach", 32'(reached), 1);
      repeat (2) tick(0, 0, 8'h00);
      repeat (40) tick(1, 0, 8'h00);
      chk("dropout_retry", 32'(bus.retry_count), 1);

      // Lock timeout
      do_reset(0);
      repeat (80) tick(0, 0, 8'h00);
      chk("tmo_sys_rst", 32'(bus.sys_rst), 1);
      chk("tmo_retry", 32'(bus.retry_count), 3);

      // Async reset between edges during SETTLE
      do_reset(1);
      reached = 0;
      for (int i = 0; i < 100 && !reached; i++) begin
         tick(1, 0, 8'h00);
         reached = (ph == P_SET);
      end
      chk("settle_reach2", 32'(reached), 1);
      repeat (2) tick(1, 0, 8'h00);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_vals("async");
      @(negedge clk);
      rst = 1'b0;
      repeat (30) tick(1, 0, 8'h00);

      // Randomized stimulus
      lk = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) lk = ~lk;
         stp = ($urandom_range(0, 199) == 0);
         tick(lk, stp, 8'($urandom));
      end

      // Saturation over 300 timeouts
      do_reset(0);
      repeat (300 * (LT + RP) + 10) tick(0, 0, 8'h00);
      chk("sat_retry", 32'(bus.retry_count), 255);
      chk("sat_dcm_retries", 32'(retries >= 300), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
